// File: rtl/wb_slave_mem.sv
// Wishbone slave memory: byte-lane 32-bit storage, programmable wait states,
// ERR outside the address window; optional periodic RTY via WB_SLAVE_RETRY_EN.
module wb_slave_mem #(
  parameter int unsigned AW          = 8,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RTY_PERIOD  = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  TAG_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        RTY_O,
  output logic [3:0]  TAG_O,
  output logic [15:0] ACC_CNT
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

  localparam logic [31:0] WIN_MASK = 32'hFFFF_FFFF << (AW + 2);

  state_t         state;
  logic [3:0]     wcnt;
  logic [AW-1:0]  widx;
  logic           we_q;
  logic [3:0]     sel_q;
  logic [31:0]    dat_q;
  logic           in_win_q;
  logic           accept;
  logic           in_win;
  logic           mem_we;
  logic [31:0]    mem [2**AW];

  assign accept = CYC_I & STB_I;
  assign in_win = ((ADR_I ^ BASE) & WIN_MASK) == '0;

`ifdef WB_SLAVE_RETRY_EN
  logic [15:0] rty_cnt;
  logic        rty_q;
  logic        rty_hit;

  assign rty_hit = in_win && (rty_cnt == 16'(RTY_PERIOD - 1));
  assign mem_we  = (state == RESP) && in_win_q && !rty_q && we_q;
`else
  assign RTY_O  = 1'b0;
  assign mem_we = (state == RESP) && in_win_q && we_q;
`endif

  // The termination edge is the RESP->TURN edge, so ACK/ERR/RTY is high
  // while in TURN and the master's lingering STB is ignored there.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= IDLE;
      wcnt     <= '0;
      widx     <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      in_win_q <= 1'b0;
      DAT_O    <= '0;
      ACK_O    <= 1'b0;
      ERR_O    <= 1'b0;
      TAG_O    <= '0;
      ACC_CNT  <= '0;
`ifdef WB_SLAVE_RETRY_EN
      RTY_O    <= 1'b0;
      rty_cnt  <= '0;
      rty_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            widx     <= ADR_I[AW+1:2];
            we_q     <= WE_I;
            sel_q    <= SEL_I;
            dat_q    <= DAT_I;
            TAG_O    <= TAG_I;
            in_win_q <= in_win;
            wcnt     <= '0;
`ifdef WB_SLAVE_RETRY_EN
            rty_q    <= rty_hit;
            if (in_win) rty_cnt <= rty_hit ? '0 : rty_cnt + 16'd1;
`endif
            state    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (!CYC_I)                               state <= IDLE;
          else if (wcnt == 4'(WAIT_CYCLES - 1))     state <= RESP;
          else                                      wcnt  <= wcnt + 4'd1;
        end
        RESP: begin
          state <= TURN;
          if (!in_win_q) ERR_O <= 1'b1;
`ifdef WB_SLAVE_RETRY_EN
          else if (rty_q) RTY_O <= 1'b1;
`endif
          else begin
            ACK_O   <= 1'b1;
            ACC_CNT <= ACC_CNT + 16'd1;
            if (!we_q) DAT_O <= mem[widx];
          end
        end
        TURN: begin
          state <= IDLE;
          ACK_O <= 1'b0;
          ERR_O <= 1'b0;
          DAT_O <= '0;
`ifdef WB_SLAVE_RETRY_EN
          RTY_O <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a write commits only on the ACK edge.
  always_ff @(posedge CLK_I) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[widx][8*i +: 8] <= dat_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Scoreboard bench for wb_slave_mem (WAIT_CYCLES = 3, BASE = 0, AW = 8).
module tb_wb_slave_mem;

  localparam int unsigned WAITC = 3;
  localparam int unsigned RTYP  = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic [31:0] ADR_I = '0;
  logic [3:0]  SEL_I = '0;
  logic [31:0] DAT_I = '0;
  logic [3:0]  TAG_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O, ERR_O, RTY_O;
  logic [3:0]  TAG_O;
  logic [15:0] ACC_CNT;

  wb_slave_mem #(.AW(8), .BASE(32'h0000_0000), .WAIT_CYCLES(WAITC), .RTY_PERIOD(RTYP)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .SEL_I(SEL_I), .DAT_I(DAT_I), .TAG_I(TAG_I), .DAT_O(DAT_O),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O), .TAG_O(TAG_O), .ACC_CNT(ACC_CNT)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    int          kind;   // 0 ACK, 1 ERR, 2 RTY
    logic [31:0] data;
    logic        chk_data;
    logic [3:0]  tag;
    logic [15:0] acc;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit   [31:0] mdl [256];
  logic [15:0] m_acc = '0;
  int          m_rc  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_inwin(input logic [31:0] adr);
    return (adr >> 10) == 0;
  endfunction

  // Advance the retry model on an in-window accept; returns 1 if this one retries.
  function automatic bit m_accept(input logic [31:0] adr);
`ifdef WB_SLAVE_RETRY_EN
    if (!m_inwin(adr)) return 1'b0;
    if (m_rc == RTYP - 1) begin m_rc = 0; return 1'b1; end
    m_rc++;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic bus_access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [3:0] tag, input logic keep_cyc);
    exp_t e;
    int   n;
    bit   seen, rty;
    rty = m_accept(adr);
    e.tag = tag; e.chk_data = 1'b0; e.data = '0;
    if (!m_inwin(adr)) begin
      e.kind = 1; e.chk_data = 1'b1;
    end else if (rty) begin
      e.kind = 2; e.chk_data = 1'b1;
    end else begin
      e.kind = 0;
      m_acc++;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (sel[i]) mdl[adr[9:2]][8*i +: 8] = dat[8*i +: 8];
      end else begin
        e.data = mdl[adr[9:2]]; e.chk_data = 1'b1;
      end
    end
    e.acc = m_acc;
    sbq.push_back(e);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; SEL_I = sel; DAT_I = dat; TAG_I = tag;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge CLK_I); #1;
      n++;
      if (ACK_O | ERR_O | RTY_O) seen = 1;
    end
    check_val("latency", n, WAITC + 2);
    STB_I = 1'b0;
    if (!keep_cyc) CYC_I = 1'b0;
    @(posedge CLK_I); #1;
    check_val("pulse_width", {29'd0, ACK_O, ERR_O, RTY_O}, '0);
  endtask

  always @(negedge CLK_I) begin
    if (ACK_O | ERR_O | RTY_O) begin
      check_val("onehot", 32'(ACK_O) + 32'(ERR_O) + 32'(RTY_O), 1);
      if (sbq.size() == 0) begin
        check_val("unexpected_term", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_val("kind", ACK_O ? 0 : (ERR_O ? 1 : 2), e.kind);
        check_val("tag", TAG_O, e.tag);
        check_val("acc_cnt", ACC_CNT, e.acc);
        if (e.chk_data) check_val("dat", DAT_O, e.data);
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK_I);
    #1;
    check_val("rst_ack", ACK_O, 0);
    check_val("rst_err", ERR_O, 0);
    check_val("rst_rty", RTY_O, 0);
    check_val("rst_dat", DAT_O, 0);
    check_val("rst_tag", TAG_O, 0);
    check_val("rst_acc", ACC_CNT, 0);
    @(negedge CLK_I); RST_I = 1'b1;
    @(posedge CLK_I); #1;

    bus_access(1, 32'h10, 4'hF, 32'hDEADBEEF, 4'h1, 0);
    bus_access(0, 32'h10, 4'hF, 32'h0, 4'h9, 0);
    bus_access(1, 32'h20, 4'hF, 32'h11223344, 4'h2, 0);
    bus_access(1, 32'h20, 4'b0001, 32'h000000AA, 4'h3, 0);
    bus_access(0, 32'h20, 4'hF, 32'h0, 4'h4, 0);
    bus_access(1, 32'h20, 4'b0000, 32'hFFFFFFFF, 4'h5, 0);
    bus_access(0, 32'h20, 4'hF, 32'h0, 4'h6, 0);
    bus_access(0, 32'h8000_0000, 4'hF, 32'h0, 4'h7, 0);
    bus_access(1, 32'h8000_0010, 4'hF, 32'h0BAD0BAD, 4'h8, 0);
    bus_access(0, 32'h10, 4'hF, 32'h0, 4'hA, 0);
    bus_access(1, 32'h30, 4'hF, 32'h77777777, 4'hB, 0);
    bus_access(1, 32'h40, 4'hF, 32'h0000_4040, 4'hC, 0);

    // CYC dropped while waiting: no termination, no write.
    void'(m_accept(32'h40));
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h40; SEL_I = 4'hF; DAT_I = 32'hFFFF_0000; TAG_I = 4'hD;
    @(posedge CLK_I); #1;
    @(posedge CLK_I); #1;
    CYC_I = 1'b0; STB_I = 1'b0;
    repeat (8) @(posedge CLK_I);
    #1;
    bus_access(0, 32'h40, 4'hF, 32'h0, 4'hE, 0);

    // Read-modify-write with CYC held across both accesses.
    bus_access(0, 32'h30, 4'hF, 32'h0, 4'h1, 1);
    bus_access(1, 32'h30, 4'hF, 32'h5, 4'h2, 0);
    bus_access(0, 32'h30, 4'hF, 32'h0, 4'h3, 0);

    // Asynchronous reset during the wait phase of a write.
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h10; SEL_I = 4'hF; DAT_I = 32'hCAFEF00D; TAG_I = 4'h6;
    @(posedge CLK_I); #1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    #1;
    check_val("midrst_ack", {ACK_O, ERR_O, RTY_O}, 0);
    check_val("midrst_tag", TAG_O, 0);
    check_val("midrst_acc", ACC_CNT, 0);
    check_val("midrst_dat", DAT_O, 0);
    CYC_I = 1'b0; STB_I = 1'b0;
    m_acc = '0; m_rc = 0;
    @(negedge CLK_I); RST_I = 1'b1;
    @(posedge CLK_I); #1;

    // Eight reads from a cleared counter; with retry enabled 4th and 8th retry.
    for (int i = 0; i < 8; i++)
      bus_access(0, 32'h10 + 32'((i % 4) * 16), 4'hF, 32'h0, 4'(i), 0);
`ifdef WB_SLAVE_RETRY_EN
    check_val("acc_final", ACC_CNT, 6);
`else
    check_val("acc_final", ACC_CNT, 8);
`endif
    check_val("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
- Behavioural-plus-synthesizable Wishbone slave memory.
- Sits directly downstream of the bench Wishbone master and consumes its single, block and RMW cycles.
- Provides byte-lane-granular 32-bit storage, programmable wait states and ERR on out-of-window addresses.
- Echoes TAG so the bench can check response ordering.

Parameters:
- AW, 8, word-address width; depth = 2**AW 32-bit words.
- BASE, 32'h0000_0000, window base; ADR_I[31:AW+2] must equal BASE[31:AW+2].
- WAIT_CYCLES, 1, extra cycles between accept and ACK/ERR/RTY (0..15).
- RTY_PERIOD, 4, every RTY_PERIOD-th accepted access answers RTY (only with the optional feature).

Ports:
- CLK_I  in  1  clock, rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- CYC_I  in  1  bus cycle valid.
- STB_I  in  1  strobe.
- WE_I  in  1  1 = write.
- ADR_I  in  32  byte address; word select is ADR_I[AW+1:2].
- SEL_I  in  4  byte-lane enables; SEL_I[0] = DAT[7:0].
- DAT_I  in  32  write data.
- TAG_I  in  4  request tag.
- DAT_O  out  32  read data, valid only while ACK_O = 1.
- ACK_O  out  1  normal termination.
- ERR_O  out  1  error termination.
- RTY_O  out  1  retry termination.
- TAG_O  out  4  tag captured at accept, valid with any termination.
- ACC_CNT  out  16  count of ACK terminations, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (RST_I low, asynchronous):
  - state = IDLE.
  - ACK_O, ERR_O, RTY_O = 0; DAT_O = 0; TAG_O = 0; ACC_CNT = 0; wait counter = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE:
  - Accept when CYC_I & STB_I are high at an edge.
  - At accept, capture ADR_I, WE_I, SEL_I, DAT_I, TAG_I.
  - Go to WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - Counts WAIT_CYCLES edges, then goes to RESP.
  - If CYC_I is sampled low in WAIT, abort: go to IDLE with no write and no termination.
- RESP:
  - Exactly one termination output is high for exactly one cycle.
  - Latency: accept at edge k means the termination is driven high by edge k+1+WAIT_CYCLES.
- Termination select (priority): ERR if the address is out of window, else RTY (optional feature), else ACK.
- ACK write:
  - Memory byte lane i is written with DAT_I[8i+7:8i] when SEL_I[i] = 1, committed at the edge that asserts ACK_O.
  - SEL_I = 0 completes with ACK and writes nothing.
- ACK read:
  - DAT_O = full stored word (all 4 lanes, SEL ignored), driven with ACK_O.
  - DAT_O returns to 0 the next cycle.
- ERR/RTY: no memory write; DAT_O = 0.
- ACC_CNT increments on each ACK, read or write.
- TURN:
  - Mandatory one-cycle state after RESP; STB_I is ignored.
  - Covers the master still presenting STB at the edge it samples ACK.
  - Then IDLE; back-to-back accesses are therefore spaced at least 3 + WAIT_CYCLES cycles.
- CYC_I held high across RESP/TURN (block, RMW) is legal; the next STB_I is accepted in IDLE.
- A write following a read to the same word in one RMW cycle sees the read value already committed.
- Reset asserted mid-transaction:
  - Any termination drops immediately.
  - A pending write is discarded, because the write commits only in RESP.

Optional Feature:
- Macro WB_SLAVE_RETRY_EN.
- Defined:
  - An internal accept counter (modulo RTY_PERIOD) advances on every in-window accept.
  - When it reaches RTY_PERIOD-1, that access terminates with RTY_O, no write, the counter resets, and ACC_CNT is unchanged.
  - ERR still has priority.
- Undefined: RTY_O is tied to 0, no counter logic exists, and all in-window accesses ACK.

Test Plan:
- Reset then single write 32'hDEADBEEF, SEL 4'hF to 0x10, then read 0x10 -> ACK each one cycle; read DAT_O = 32'hDEADBEEF; ACC_CNT = 2.
- Byte-lane write 32'h000000AA, SEL 4'b0001 over 32'h11223344 at 0x20 -> read 32'h112233AA; SEL 4'b0000 write leaves it unchanged but still ACKs.
- WAIT_CYCLES = 3, STB accepted at edge k -> ACK high after edge k+4 only; TAG_I = 4'h9 -> TAG_O = 4'h9 with ACK.
- Access to 32'h8000_0000 with BASE = 0 -> ERR_O one cycle, no write, ACC_CNT unchanged; CYC_I dropped during WAIT -> no termination, memory unchanged.
- RMW on 0x30 (read then write 32'h5, CYC held) -> two ACKs separated by the TURN cycle; final read = 32'h5. Async reset asserted during WAIT of a write -> outputs 0 immediately; word unchanged.
- WB_SLAVE_RETRY_EN with RTY_PERIOD = 4, eight reads -> 4th and 8th get RTY_O, others ACK; ACC_CNT = 6.
